// File: rtl/glitch_sequencer.sv
// glitch_sequencer: boot-attempt sequencer for the S-RGH glitch core.
// Counts POST edges to locate the glitch point, slows the CPU, requests a
// glitch, then watches for POST progress; a dead attempt pulses a console
// reset and retries until the retry budget is spent.
//
// state | meaning
// IDLE  | disabled; waiting for enable
// COUNT | counting POST edges towards the glitch point
// SLOW  | cpu_slow asserted, settling before the glitch request
// ARM   | glitch request held high (cpu_slow still high)
// CHECK | watching for post-glitch POST progress
// RESET | console reset request pulse, then retry or give up
// DONE  | boot progressed; held until enable drops
// FAIL  | retry budget exhausted; held until enable drops
module glitch_sequencer #(
  parameter int POST_TARGET  = 6,
  parameter int SLOW_CYCLES  = 9600,
  parameter int GLITCH_HOLD  = 17000,
  parameter int OK_EDGES     = 2,
  parameter int BOOT_TIMEOUT = 9600000,
  parameter int RESET_CYCLES = 960,
  parameter int MAX_RETRIES  = 15
) (
  input  logic       clk_96m,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       post_bit,
  output logic       glitch,
  output logic       cpu_slow,
  output logic       reset_req,
  output logic       busy,
  output logic       success,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_SLOW  = 3'd2;
  localparam logic [2:0] ST_ARM   = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_RESET = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_FAIL  = 3'd7;

  localparam logic [3:0]  POST_TGT     = 4'(POST_TARGET);
  localparam logic [3:0]  OK_TGT       = 4'(OK_EDGES);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRIES);
  localparam logic [23:0] SLOW_LAST    = 24'(SLOW_CYCLES - 1);
  localparam logic [23:0] HOLD_LAST    = 24'(GLITCH_HOLD - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(BOOT_TIMEOUT - 1);
  localparam logic [23:0] RESET_LAST   = 24'(RESET_CYCLES - 1);

  logic [2:0]  state, state_nxt;
  logic [3:0]  post_cnt, post_cnt_nxt, post_cnt_inc;
  logic [3:0]  retry_nxt, retry_inc;
  logic [23:0] timer;
  logic        timer_clr;
  logic        sync_1, sync_2, sync_3;
  logic        post_edge;

  assign post_edge    = sync_2 ^ sync_3;
  assign post_cnt_inc = post_cnt + 4'd1;
  assign retry_inc    = retry_cnt + 4'd1;
  assign state_dbg    = state;

  // Bring the asynchronous POST bit into clk_96m and keep one extra stage for edge detect
  always_ff @(posedge clk_96m or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
    end else begin
      sync_1 <= post_bit;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

  // Next-state and counter decisions; enable low overrides every other event
  always_comb begin
    state_nxt    = state;
    post_cnt_nxt = post_cnt;
    retry_nxt    = retry_cnt;
    timer_clr    = 1'b0;
    if (!enable) begin
      state_nxt    = ST_IDLE;
      post_cnt_nxt = 4'd0;
      retry_nxt    = 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt    = ST_COUNT;
          post_cnt_nxt = 4'd0;
          retry_nxt    = 4'd0;
        end
        ST_COUNT: begin
          if (post_edge) begin
            timer_clr = 1'b1;
            if (post_cnt_inc == POST_TGT) begin
              state_nxt    = ST_SLOW;
              post_cnt_nxt = 4'd0;
            end else begin
              post_cnt_nxt = post_cnt_inc;
            end
          end else if (timer == TIMEOUT_LAST) begin
            state_nxt = ST_RESET;
          end
        end
        ST_SLOW: begin
          if (timer == SLOW_LAST) state_nxt = ST_ARM;
        end
        ST_ARM: begin
          if (timer == HOLD_LAST) state_nxt = ST_CHECK;
        end
        ST_CHECK: begin
          // An edge on the timeout cycle counts and restarts the timeout
          if (post_edge) begin
            timer_clr = 1'b1;
            if (post_cnt_inc == OK_TGT) begin
              state_nxt    = ST_DONE;
              post_cnt_nxt = 4'd0;
            end else begin
              post_cnt_nxt = post_cnt_inc;
            end
          end else if (timer == TIMEOUT_LAST) begin
            state_nxt = ST_RESET;
          end
        end
        ST_RESET: begin
          if (timer == RESET_LAST) begin
            retry_nxt    = retry_inc;
            post_cnt_nxt = 4'd0;
            state_nxt    = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_COUNT;
          end
        end
        ST_DONE, ST_FAIL: begin
          state_nxt = state;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, POST edge count and retry count registers
  always_ff @(posedge clk_96m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      post_cnt  <= 4'd0;
      retry_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      post_cnt  <= post_cnt_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  // Shared timer: restarts on every state entry and on counted POST edges, saturates at all-ones
  always_ff @(posedge clk_96m or negedge rst_n) begin
    if (!rst_n) begin
      timer <= 24'd0;
    end else if (timer_clr || (state_nxt != state)) begin
      timer <= 24'd0;
    end else if (timer != '1) begin
      timer <= timer + 24'd1;
    end
  end

  // Outputs registered from the next state so they line up with the state register
  always_ff @(posedge clk_96m or negedge rst_n) begin
    if (!rst_n) begin
      glitch    <= 1'b0;
      cpu_slow  <= 1'b0;
      reset_req <= 1'b0;
      busy      <= 1'b0;
      success   <= 1'b0;
      fail      <= 1'b0;
    end else begin
      glitch    <= (state_nxt == ST_ARM);
      cpu_slow  <= (state_nxt == ST_SLOW) || (state_nxt == ST_ARM);
      reset_req <= (state_nxt == ST_RESET);
      busy      <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE) && (state_nxt != ST_FAIL);
      success   <= (state_nxt == ST_DONE);
      fail      <= (state_nxt == ST_FAIL);
    end
  end

endmodule
